// File: rtl/filt_ppi_ctrl.sv
// Sequencer for a single-MAC polyphase interpolator: shifts the delay line once
// per sample, then walks every phase/tap pair issuing coefficient and tap addresses.
module filt_ppi_ctrl #(
  parameter int gp_interpolation_factor = 4,
  parameter int gp_coeff_length         = 12,
  parameter bit gp_comm_ccw             = 1'b1
) (
  input  logic          i_clk,
  input  logic          i_rst_an,
  input  logic          i_ena,
  input  logic          i_sample_valid,
  input  logic          i_err_clr,
  output logic          o_ready,
  output logic          o_shift,
  output logic          o_mac_en,
  output logic          o_acc_clr,
  output logic          o_acc_last,
  output logic [(gp_interpolation_factor > 1 ? $clog2(gp_interpolation_factor) : 1)-1:0] o_phase,
  output logic [(((gp_coeff_length + gp_interpolation_factor - 1) / gp_interpolation_factor) > 1 ?
                 $clog2((gp_coeff_length + gp_interpolation_factor - 1) / gp_interpolation_factor) : 1)-1:0] o_tap,
  output logic [(gp_coeff_length > 1 ? $clog2(gp_coeff_length) : 1)-1:0] o_coeff_addr,
  output logic          o_coeff_zero,
  output logic          o_ovf_err
);

  localparam int L  = gp_interpolation_factor;
  localparam int N  = gp_coeff_length;
  localparam int gp_taps_per_phase = (N + L - 1) / L;
  localparam int K  = gp_taps_per_phase;
  localparam int PW = (L > 1) ? $clog2(L) : 1;
  localparam int KW = (K > 1) ? $clog2(K) : 1;
  localparam int AW = (N > 1) ? $clog2(N) : 1;

  localparam logic [PW-1:0] FIRST_PHASE = gp_comm_ccw ? PW'(0) : PW'(L - 1);
  localparam logic [PW-1:0] LAST_PHASE  = gp_comm_ccw ? PW'(L - 1) : PW'(0);
  localparam logic [KW-1:0] LAST_TAP    = KW'(K - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_MAC} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic [KW-1:0]   tap_q, tap_d;
  logic [AW-1:0]   coeff_addr_q, coeff_addr_d;
  logic            shift_q, shift_d;
  logic            mac_en_q, mac_en_d;
  logic            acc_clr_q, acc_clr_d;
  logic            acc_last_q, acc_last_d;
  logic            coeff_zero_q, coeff_zero_d;
  logic            ovf_q, ovf_d;
  logic            in_mac;
  logic            final_tap;
  logic [31:0]     coeff_idx;

  assign final_tap = (state_q == ST_MAC) && (tap_q == LAST_TAP) && (phase_q == LAST_PHASE);
  assign o_ready   = (state_q == ST_IDLE) || final_tap;

  // Outputs are registered from the next-state indices, so they line up with the state they describe.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    tap_d        = tap_q;
    coeff_addr_d = coeff_addr_q;
    coeff_zero_d = coeff_zero_q;
    shift_d      = 1'b0;
    mac_en_d     = 1'b0;
    acc_clr_d    = 1'b0;
    acc_last_d   = 1'b0;
    ovf_d        = ovf_q;
    in_mac       = 1'b0;
    coeff_idx    = '0;
    if (i_ena) begin
      if (i_sample_valid && !o_ready) begin
        ovf_d = 1'b1;
      end else if (i_err_clr) begin
        ovf_d = 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          phase_d = '0;
          tap_d   = '0;
          if (i_sample_valid) begin
            state_d = ST_SHIFT;
            shift_d = 1'b1;
          end
        end
        ST_SHIFT: begin
          state_d = ST_MAC;
          phase_d = FIRST_PHASE;
          tap_d   = '0;
        end
        ST_MAC: begin
          if (final_tap) begin
            phase_d = '0;
            tap_d   = '0;
            if (i_sample_valid) begin
              state_d = ST_SHIFT;
              shift_d = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end else if (tap_q == LAST_TAP) begin
            tap_d   = '0;
            phase_d = gp_comm_ccw ? phase_q + PW'(1) : phase_q - PW'(1);
          end else begin
            tap_d = tap_q + KW'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          phase_d = '0;
          tap_d   = '0;
        end
      endcase
      in_mac       = (state_d == ST_MAC);
      mac_en_d     = in_mac;
      acc_clr_d    = in_mac && (tap_d == '0);
      acc_last_d   = in_mac && (tap_d == LAST_TAP);
      coeff_idx    = 32'(tap_d) * 32'(L) + 32'(phase_d);
      coeff_zero_d = in_mac && (coeff_idx >= 32'(N));
      coeff_addr_d = (in_mac && !coeff_zero_d) ? AW'(coeff_idx) : '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_an) begin
    if (!i_rst_an) begin
      state_q      <= ST_IDLE;
      phase_q      <= '0;
      tap_q        <= '0;
      coeff_addr_q <= '0;
      coeff_zero_q <= 1'b0;
      shift_q      <= 1'b0;
      mac_en_q     <= 1'b0;
      acc_clr_q    <= 1'b0;
      acc_last_q   <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      tap_q        <= tap_d;
      coeff_addr_q <= coeff_addr_d;
      coeff_zero_q <= coeff_zero_d;
      shift_q      <= shift_d;
      mac_en_q     <= mac_en_d;
      acc_clr_q    <= acc_clr_d;
      acc_last_q   <= acc_last_d;
      ovf_q        <= ovf_d;
    end
  end

  assign o_shift      = shift_q;
  assign o_mac_en     = mac_en_q;
  assign o_acc_clr    = acc_clr_q;
  assign o_acc_last   = acc_last_q;
  assign o_phase      = phase_q;
  assign o_tap        = tap_q;
  assign o_coeff_addr = coeff_addr_q;
  assign o_coeff_zero = coeff_zero_q;
  assign o_ovf_err    = ovf_q;

endmodule

// File: tb/tb_filt_ppi_ctrl.sv
// Bench for filt_ppi_ctrl: three configurations share one stimulus stream and are
// checked every cycle against a position-in-sample reference model.
module tb_filt_ppi_ctrl;

  localparam int L = 4;
  localparam int K = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, ena, valid, err_clr;

  logic [2:0] ready, shift, mac_en, acc_clr, acc_last, coeff_zero, ovf;
  logic [1:0] phase [3];
  logic [1:0] tap   [3];
  logic [3:0] addr  [3];

  int n_of   [3] = '{12, 10, 12};
  bit ccw_of [3] = '{1'b1, 1'b1, 1'b0};

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int mpos;
  bit movf;
  bit mena;

  bit capture_on = 1'b0;
  int cap_addr_a [$];
  int cap_addr_b [$];
  int cap_zero_b [$];
  int cap_addr_c [$];
  int cap_phase_c [$];

  filt_ppi_ctrl #(.gp_interpolation_factor(4), .gp_coeff_length(12), .gp_comm_ccw(1'b1)) dut_a (
    .i_clk(clk), .i_rst_an(rst_n), .i_ena(ena), .i_sample_valid(valid), .i_err_clr(err_clr),
    .o_ready(ready[0]), .o_shift(shift[0]), .o_mac_en(mac_en[0]), .o_acc_clr(acc_clr[0]),
    .o_acc_last(acc_last[0]), .o_phase(phase[0]), .o_tap(tap[0]), .o_coeff_addr(addr[0]),
    .o_coeff_zero(coeff_zero[0]), .o_ovf_err(ovf[0]));

  filt_ppi_ctrl #(.gp_interpolation_factor(4), .gp_coeff_length(10), .gp_comm_ccw(1'b1)) dut_b (
    .i_clk(clk), .i_rst_an(rst_n), .i_ena(ena), .i_sample_valid(valid), .i_err_clr(err_clr),
    .o_ready(ready[1]), .o_shift(shift[1]), .o_mac_en(mac_en[1]), .o_acc_clr(acc_clr[1]),
    .o_acc_last(acc_last[1]), .o_phase(phase[1]), .o_tap(tap[1]), .o_coeff_addr(addr[1]),
    .o_coeff_zero(coeff_zero[1]), .o_ovf_err(ovf[1]));

  filt_ppi_ctrl #(.gp_interpolation_factor(4), .gp_coeff_length(12), .gp_comm_ccw(1'b0)) dut_c (
    .i_clk(clk), .i_rst_an(rst_n), .i_ena(ena), .i_sample_valid(valid), .i_err_clr(err_clr),
    .o_ready(ready[2]), .o_shift(shift[2]), .o_mac_en(mac_en[2]), .o_acc_clr(acc_clr[2]),
    .o_acc_last(acc_last[2]), .o_phase(phase[2]), .o_tap(tap[2]), .o_coeff_addr(addr[2]),
    .o_coeff_zero(coeff_zero[2]), .o_ovf_err(ovf[2]));

  // Packed as {shift,mac_en,acc_clr,acc_last,coeff_zero,ovf,ready,phase,tap,addr}.
  function automatic logic [14:0] observed(int i);
    return {shift[i], mac_en[i], acc_clr[i], acc_last[i], coeff_zero[i], ovf[i], ready[i],
            phase[i], tap[i], addr[i]};
  endfunction

  // pos: -1 idle, 0 shift cycle, 1..L*K the MAC steps of the current sample.
  function automatic logic [14:0] expect_out(int pos, int n, bit ccw, bit en, bit ovf_v);
    int s, ph, k, p, a;
    logic sh, mac, clr, last, z, rdy;
    logic [1:0] php, tk;
    logic [3:0] ad;
    sh = 1'b0; mac = 1'b0; clr = 1'b0; last = 1'b0; z = 1'b0;
    php = '0; tk = '0; ad = '0;
    rdy = (pos == -1) || (pos == L * K);
    if (pos == 0) sh = en;
    if (pos >= 1) begin
      s    = pos - 1;
      ph   = s / K;
      k    = s % K;
      p    = ccw ? ph : (L - 1 - ph);
      a    = k * L + p;
      mac  = en;
      clr  = en && (k == 0);
      last = en && (k == K - 1);
      z    = (a >= n);
      ad   = z ? 4'd0 : 4'(a);
      php  = 2'(p);
      tk   = 2'(k);
    end
    return {sh, mac, clr, last, z, ovf_v, rdy, php, tk, ad};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic model_step(input bit v, input bit e, input bit c);
    bit rdy;
    mena = e;
    if (e) begin
      rdy = (mpos == -1) || (mpos == L * K);
      if (v && !rdy) movf = 1'b1;
      else if (c) movf = 1'b0;
      if (mpos == -1 || mpos == L * K) mpos = v ? 0 : -1;
      else mpos = mpos + 1;
    end
  endtask

  task automatic model_reset();
    mpos = -1;
    movf = 1'b0;
    mena = 1'b1;
  endtask

  task automatic check_all(input string what);
    for (int i = 0; i < 3; i++)
      checkOutput($sformatf("%s dut%0d cyc%0d", what, i, cyc), 32'(observed(i)),
                  32'(expect_out(mpos, n_of[i], ccw_of[i], mena, movf)));
  endtask

  task automatic applyStimulus(input bit v, input bit e, input bit c);
    valid   = v;
    ena     = e;
    err_clr = c;
    @(posedge clk);
    model_step(v, e, c);
    @(negedge clk);
    cyc++;
    check_all("seq");
    if (capture_on && mac_en[0]) begin
      cap_addr_a.push_back(int'(addr[0]));
      cap_addr_b.push_back(int'(addr[1]));
      cap_zero_b.push_back(int'(coeff_zero[1]));
      cap_addr_c.push_back(int'(addr[2]));
      cap_phase_c.push_back(int'(phase[2]));
    end
  endtask

  task automatic async_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    model_reset();
    #1 check_all("rst_async");
    @(posedge clk);
    @(negedge clk);
    check_all("rst_hold");
    rst_n = 1'b1;
  endtask

  int exp_addr_a  [12] = '{0, 4, 8, 1, 5, 9, 2, 6, 10, 3, 7, 11};
  int exp_phase_c [4]  = '{3, 2, 1, 0};

  initial begin
    rst_n = 1'b0; ena = 1'b0; valid = 1'b0; err_clr = 1'b0;
    model_reset();
    #7 check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Single sample: address/phase order for all three configurations.
    capture_on = 1'b1;
    applyStimulus(1, 1, 0);
    repeat (15) applyStimulus(0, 1, 0);
    capture_on = 1'b0;
    checkOutput("cap_len", 32'(cap_addr_a.size()), 32'd12);
    if (cap_addr_a.size() == 12) begin
      for (int s = 0; s < 12; s++) begin
        checkOutput($sformatf("addr_a[%0d]", s), 32'(cap_addr_a[s]), 32'(exp_addr_a[s]));
        checkOutput($sformatf("zero_b[%0d]", s), 32'(cap_zero_b[s]), (s == 8 || s == 11) ? 32'd1 : 32'd0);
        checkOutput($sformatf("addr_b[%0d]", s), 32'(cap_addr_b[s]),
                    (s == 8 || s == 11) ? 32'd0 : 32'(exp_addr_a[s]));
      end
      checkOutput("addr_c_first", 32'(cap_addr_c[0]), 32'd3);
      for (int p = 0; p < 4; p++)
        checkOutput($sformatf("phase_c[%0d]", p), 32'(cap_phase_c[p * K]), 32'(exp_phase_c[p]));
    end

    // Back-to-back: second pulse lands on the final tap.
    applyStimulus(1, 1, 0);
    repeat (12) applyStimulus(0, 1, 0);
    applyStimulus(1, 1, 0);
    repeat (15) applyStimulus(0, 1, 0);
    checkOutput("b2b_no_ovf", 32'(ovf[0]), 32'd0);

    // Overrun mid-sequence, sticky until cleared; set wins over a simultaneous clear.
    applyStimulus(1, 1, 0);
    repeat (5) applyStimulus(0, 1, 0);
    applyStimulus(1, 1, 0);
    repeat (10) applyStimulus(0, 1, 0);
    checkOutput("ovf_sticky", 32'(ovf[0]), 32'd1);
    applyStimulus(0, 1, 1);
    applyStimulus(1, 1, 0);
    repeat (3) applyStimulus(0, 1, 0);
    applyStimulus(1, 1, 1);
    checkOutput("ovf_set_wins", 32'(ovf[0]), 32'd1);
    repeat (12) applyStimulus(0, 1, 0);
    applyStimulus(0, 1, 1);

    // Enable held low mid-sequence, and a pulse ignored while disabled in idle.
    applyStimulus(1, 1, 0);
    repeat (4) applyStimulus(0, 1, 0);
    repeat (4) applyStimulus(1, 0, 1);
    repeat (12) applyStimulus(0, 1, 0);
    applyStimulus(1, 0, 0);
    repeat (2) applyStimulus(0, 1, 0);

    // Asynchronous reset in the middle of a sequence, then a clean restart.
    applyStimulus(1, 1, 0);
    repeat (6) applyStimulus(0, 1, 0);
    async_reset();
    applyStimulus(1, 1, 0);
    repeat (14) applyStimulus(0, 1, 0);

    // Random traffic.
    for (int i = 0; i < 800; i++)
      applyStimulus(($urandom % 6) == 0, ($urandom % 100) < 85, ($urandom % 20) == 0);
    async_reset();
    for (int i = 0; i < 200; i++)
      applyStimulus(($urandom % 4) == 0, ($urandom % 100) < 90, ($urandom % 10) == 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
